// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core.
// It captures decode output, forwards operands and detects load-use hazards.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_alu_ctrl,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [2:0]  ex_alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_write_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_t;

  ex_t q, d;
  logic wb_hit_rs, wb_hit_rt;
  logic [31:0] fwd_rs, fwd_rt;

  // A register written back this cycle is not yet visible in the ID read data.
  assign wb_hit_rs = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs);
  assign wb_hit_rt = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rt);

  always_comb begin
    d            = '0;
    d.valid      = id_valid;
    d.rs         = id_rs;
    d.rt         = id_rt;
    d.write_reg  = id_reg_dst ? id_rd : id_rt;
    d.rs_val     = wb_hit_rs ? wb_data : id_rs_data;
    d.rt_val     = wb_hit_rt ? wb_data : id_rt_data;
    d.imm        = id_imm;
    d.alu_ctrl   = id_alu_ctrl;
    d.alu_src    = id_alu_src;
    d.reg_write  = id_reg_write;
    d.mem_read   = id_mem_read;
    d.mem_write  = id_mem_write;
    d.mem_to_reg = id_mem_to_reg;
  end

  // rt is compared even for I-type ops; the false stall is harmless.
  assign stall = q.valid && q.mem_read && (q.write_reg != 5'd0) && id_valid &&
                 ((q.write_reg == id_rs) || (q.write_reg == id_rt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               q <= '0;
    else if (flush || stall) q <= '0;
    else                     q <= d;
  end

  // The younger producer (MEM) wins over WB.
  always_comb begin
    fwd_rs = q.rs_val;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == q.rs))
      fwd_rs = mem_alu_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == q.rs))
      fwd_rs = wb_data;
    fwd_rt = q.rt_val;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == q.rt))
      fwd_rt = mem_alu_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == q.rt))
      fwd_rt = wb_data;
  end

  assign ex_valid      = q.valid;
  assign ex_a          = fwd_rs;
  assign ex_b          = q.alu_src ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_alu_ctrl   = q.alu_ctrl;
  assign ex_write_reg  = q.write_reg;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for capture and forwarding,
// then hand-written sequences for reset, load-use stall and flush.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [2:0]  ctrl;
    logic        valid, src, dst, rw;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_dat;
    logic [31:0] ea, eb, esd;
    logic [4:0]  ewr;
    logic        ev;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_fwd();
    mem_reg_write = 0; mem_rd = 0; mem_alu_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic id_inst(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                         input logic [2:0] ctrl, input logic src, input logic dst,
                         input logic rw, input logic mr, input logic m2r);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm; id_alu_ctrl = ctrl;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = 0; id_mem_to_reg = m2r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_a"}, ex_a, 0);
    chk({tag, "_b"}, ex_b, 0);
    chk({tag, "_sd"}, ex_store_data, 0);
    chk({tag, "_wr"}, ex_write_reg, 0);
    chk({tag, "_ctrl"}, ex_alu_ctrl, 0);
    chk({tag, "_ctl_bits"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  // lw $4, 8($1) captured into EX, then add $6,$4,$5 presented in ID.
  task automatic load_then_dep();
    id_inst(5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'd8, 3'b010, 1, 0, 1, 1, 1);
    tick();
    id_inst(5'd4, 5'd5, 5'd6, 32'h0, 32'h30, 32'h0, 3'b010, 0, 1, 1, 0, 0);
    #1;
  endtask

  initial begin
    //          rs  rt  rd  rs_d     rt_d     imm           ctrl    v src dst rw  m_rw m_rd m_res     w_rw w_rd w_dat     ea       eb           esd      ewr ev
    vecs[0] = '{5'd1, 5'd9, 5'd2, 32'd5, 32'h11, 32'd7, 3'b010, 1, 1, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'd5, 32'd7, 32'h11, 5'd9, 1};
    vecs[1] = '{5'd4, 5'd3, 5'd12, 32'h100, 32'h200, 32'h0, 3'b110, 1, 0, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'h100, 32'h200, 32'h200, 5'd12, 1};
    vecs[2] = '{5'd5, 5'd6, 5'd0, 32'd1, 32'd2, 32'h0, 3'b011, 1, 0, 0, 0, 1, 5'd6, 32'hAA, 0, 5'd0, 32'h0,
                32'd1, 32'hAA, 32'hAA, 5'd6, 1};
    vecs[3] = '{5'd7, 5'd8, 5'd0, 32'd0, 32'd3, 32'hFFFF_FFFF, 3'b001, 1, 1, 0, 1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h55,
                32'h55, 32'hFFFF_FFFF, 32'd3, 5'd8, 1};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 32'h10, 32'h20, 32'h0, 3'b000, 1, 0, 0, 1, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF,
                32'h10, 32'h20, 32'h20, 5'd0, 1};
    vecs[5] = '{5'd10, 5'd11, 5'd0, 32'd3, 32'd4, 32'd5, 3'b010, 0, 1, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'd3, 32'd5, 32'd4, 5'd11, 0};
    vecs[6] = '{5'd3, 5'd2, 5'd9, 32'd1, 32'h22, 32'h0, 3'b111, 1, 0, 1, 1, 1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB,
                32'hAA, 32'h22, 32'h22, 5'd9, 1};

    reset = 1; flush = 0; clear_fwd();
    id_inst(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 0, 0);
    id_valid = 0;
    tick(); tick();
    chk_zero("rst_init");
    reset = 0;

    for (int i = 0; i < 7; i++) begin
      id_inst(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm,
              vecs[i].ctrl, vecs[i].src, vecs[i].dst, vecs[i].rw, 0, 0);
      id_valid = vecs[i].valid;
      mem_reg_write = vecs[i].m_rw; mem_rd = vecs[i].m_rd; mem_alu_result = vecs[i].m_res;
      wb_reg_write = vecs[i].w_rw; wb_rd = vecs[i].w_rd; wb_data = vecs[i].w_dat;
      tick();
      chk($sformatf("v%0d_a", i), ex_a, vecs[i].ea);
      chk($sformatf("v%0d_b", i), ex_b, vecs[i].eb);
      chk($sformatf("v%0d_sd", i), ex_store_data, vecs[i].esd);
      chk($sformatf("v%0d_wr", i), ex_write_reg, vecs[i].ewr);
      chk($sformatf("v%0d_ctrl", i), ex_alu_ctrl, vecs[i].ctrl);
      chk($sformatf("v%0d_valid", i), ex_valid, vecs[i].ev);
      chk($sformatf("v%0d_rw", i), ex_reg_write, vecs[i].rw);
      chk($sformatf("v%0d_stall", i), stall, 0);
    end

    // EX holds rs=3 from the last vector; vary the forwarding sources live.
    mem_reg_write = 0; #1;
    chk("prio_wb_only", ex_a, 32'hBB);
    mem_reg_write = 1; mem_rd = 0; #1;
    chk("prio_mem_rd0", ex_a, 32'hBB);
    wb_reg_write = 0; #1;
    chk("prio_none", ex_a, 32'hBB);

    // Capture-time WB bypass, then WB goes quiet.
    clear_fwd();
    id_inst(5'd1, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 3'b010, 0, 0, 0, 0, 0);
    wb_reg_write = 1; wb_rd = 6; wb_data = 32'h1234;
    tick();
    clear_fwd(); #1;
    chk("bypass_sd", ex_store_data, 32'h1234);
    chk("bypass_b", ex_b, 32'h1234);

    // Load-use: one stall cycle, one bubble, then capture with bypassed load data.
    load_then_dep();
    chk("lu_stall", stall, 1);
    chk("lu_ex_load", ex_mem_read, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_rw", ex_reg_write, 0);
    chk("lu_bub_mr", ex_mem_read, 0);
    chk("lu_stall_gone", stall, 0);
    wb_reg_write = 1; wb_rd = 4; wb_data = 32'h77;
    tick();
    clear_fwd(); #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_a", ex_a, 32'h77);
    chk("lu_add_b", ex_b, 32'h30);
    chk("lu_add_wr", ex_write_reg, 6);
    chk("lu_add_stall", stall, 0);

    // Flush while stalled gives a single bubble.
    load_then_dep();
    chk("fl_stall", stall, 1);
    flush = 1;
    tick();
    flush = 0; #1;
    chk("fl_valid", ex_valid, 0);
    chk("fl_ctl_bits", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    chk("fl_stall", stall, 0);
    tick();
    chk("fl_next_valid", ex_valid, 1);
    chk("fl_next_wr", ex_write_reg, 6);

    // Asynchronous reset mid-stall, no clock edge in between.
    load_then_dep();
    chk("rs_stall", stall, 1);
    reset = 1; #1;
    chk_zero("rst_mid");
    #1 reset = 0;
    tick();
    chk("rst_cap_valid", ex_valid, 1);
    chk("rst_cap_wr", ex_write_reg, 6);
    chk("rst_cap_b", ex_b, 32'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
